// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit fetch/execute controller.
// Holds the opcode map, flag bit positions, instruction field slices and the
// controller state type. Imported by alu_ctrl and reg_file_4x4.
package cpu_pkg;

  // Opcodes, instruction bits [11:8]
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_CMP  = 4'h3;
  localparam logic [3:0] OP_RSH  = 4'h4;
  localparam logic [3:0] OP_LSH  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JE   = 4'h9;
  localparam logic [3:0] OP_JG   = 4'hA;
  localparam logic [3:0] OP_JL   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Flag bit positions, shared by alu_eflags and the flags register
  localparam int unsigned FL_C = 0;
  localparam int unsigned FL_V = 1;
  localparam int unsigned FL_N = 2;
  localparam int unsigned FL_Z = 3;

  // Instruction layout: [11:8] opcode, [7:6] rd, [5:4] rs, [3:0] imm4
  localparam int unsigned INSTR_W = 12;
  localparam int unsigned OPC_MSB = 11;
  localparam int unsigned OPC_LSB = 8;
  localparam int unsigned RD_MSB  = 7;
  localparam int unsigned RD_LSB  = 6;
  localparam int unsigned RS_MSB  = 5;
  localparam int unsigned RS_LSB  = 4;
  localparam int unsigned IMM_MSB = 3;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt
  } ctrl_state_t;

  // Opcodes that are forwarded to the ALU; everything else presents OP_NOP.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_CMP) ||
           (op == OP_RSH) || (op == OP_LSH);
  endfunction

endpackage

// File: rtl/reg_file_4x4.sv
// Four 4-bit architectural registers.
// Ports:
//   clk_i, rst_ni        clock and synchronous active-low clear
//   we_i/waddr_i/wdata_i synchronous write port
//   raddr_a_i/rdata_a_o  combinational read port A
//   raddr_b_i/rdata_b_o  combinational read port B
//   dbg_sel_i/dbg_data_o combinational debug read port
module reg_file_4x4
  import cpu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [3:0] wdata_i,
  input  logic [1:0] raddr_a_i,
  output logic [3:0] rdata_a_o,
  input  logic [1:0] raddr_b_i,
  output logic [3:0] rdata_b_o,
  input  logic [1:0] dbg_sel_i,
  output logic [3:0] dbg_data_o
);

  logic [3:0] regs_q [4];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/alu_ctrl.sv
// Fetch/execute controller that sequences an external 4-bit ALU into a
// minimal processor core. Each instruction takes one FETCH phase (stretched
// until imem_valid) and exactly one EXEC cycle.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start                  begin execution at pc 0 from IDLE or HALT
//   imem_req/addr/valid/rdata  instruction fetch handshake
//   alu_opcode/op1/op2     ALU inputs, driven only during EXEC
//   alu_dout/alu_eflags    ALU result and flags
//   flags, pc              architectural flags and program counter
//   busy, halted           FETCH/EXEC and HALT status
//   dbg_sel/dbg_data       combinational register-file read for debug
module alu_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W            = 4,
  parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_valid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [3:0]          alu_opcode,
  output logic [3:0]          alu_op1,
  output logic [3:0]          alu_op2,
  input  logic [3:0]          alu_dout,
  input  logic [3:0]          alu_eflags,
  output logic [3:0]          flags,
  output logic [PC_W-1:0]     pc,
  output logic                busy,
  output logic                halted,
  input  logic [1:0]          dbg_sel,
  output logic [3:0]          dbg_data
);

  ctrl_state_t        state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [3:0]         flags_q, flags_d;

  logic [3:0] opc;
  logic [1:0] rd_idx, rs_idx;
  logic [3:0] imm4;
  logic [3:0] rd_data, rs_data;
  logic       rf_we;
  logic [3:0] rf_wdata;
  logic [PC_W-1:0] pc_inc, pc_target;

  assign opc    = instr_q[OPC_MSB:OPC_LSB];
  assign rd_idx = instr_q[RD_MSB:RD_LSB];
  assign rs_idx = instr_q[RS_MSB:RS_LSB];
  assign imm4   = instr_q[IMM_MSB:IMM_LSB];

  // Wraps modulo 2**PC_W by natural overflow.
  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_target = PC_W'(imm4);

  reg_file_4x4 u_rf (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rd_idx),
    .wdata_i    (rf_wdata),
    .raddr_a_i  (rd_idx),
    .rdata_a_o  (rd_data),
    .raddr_b_i  (rs_idx),
    .rdata_b_o  (rs_data),
    .dbg_sel_i  (dbg_sel),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    flags_d    = flags_q;
    rf_we      = 1'b0;
    rf_wdata   = alu_dout;
    imem_req   = 1'b0;
    alu_opcode = OP_NOP;
    alu_op1    = '0;
    alu_op2    = '0;
    busy       = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end

      StFetch: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = StExec;
        end
      end

      StExec: begin
        busy    = 1'b1;
        alu_op1 = rd_data;
        alu_op2 = rs_data;
        if (is_alu_op(opc)) begin
          alu_opcode = opc;
        end
        state_d = StFetch;
        pc_d    = pc_inc;
        case (opc)
          OP_NOP: ;
          OP_ADD: begin
            rf_we   = 1'b1;
            flags_d = alu_eflags;
          end
          OP_MUL, OP_RSH, OP_LSH: rf_we = 1'b1;
          OP_CMP: flags_d = alu_eflags;
          OP_LDI: begin
            rf_we    = 1'b1;
            rf_wdata = imm4;
          end
          // Conditional jumps test the stored flags, never the live ALU flags.
          OP_JMP: pc_d = pc_target;
          OP_JE:  if (flags_q[FL_Z]) pc_d = pc_target;
          OP_JG:  if (!flags_q[FL_Z] && !flags_q[FL_N]) pc_d = pc_target;
          OP_JL:  if (flags_q[FL_N]) pc_d = pc_target;
          OP_HALT: begin
            state_d = StHalt;
            pc_d    = pc_q;
          end
          default: begin
            if (HALT_ON_ILLEGAL) begin
              state_d = StHalt;
              pc_d    = pc_q;
            end
          end
        endcase
      end

      StHalt: begin
        halted = 1'b1;
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign flags     = flags_q;

endmodule
